// File: rtl/pe_array_scheduler.sv
// pe_array_scheduler
// Job-level controller for the pe_wrapper convolution array.
//   - Holds the KxK weight bank (written over cfg_wr/cfg_addr/cfg_data while idle)
//     and presents it flat on pe_weightsIn, entry i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH].
//   - start/num_vectors launch a job; abort cancels it; busy/done report job status.
//   - in_valid/in_ready/in_data: upstream vector stream; each accepted vector is
//     registered onto pe_en/pe_dataIn for one cycle.
//   - out_valid/out_index tag the array result PIPE_LATENCY cycles after pe_en.
module pe_array_scheduler #(
    parameter int KERNEL_SIZE  = 3,
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int PIPE_LATENCY = 4,
    parameter int CNT_W        = 16,
    parameter int IDX_W        = 4
) (
    input  logic                                       clk,
    input  logic                                       rstn,
    input  logic                                       cfg_wr,
    input  logic [IDX_W-1:0]                           cfg_addr,
    input  logic [WEIGHT_WIDTH-1:0]                    cfg_data,
    input  logic                                       start,
    input  logic                                       abort,
    input  logic [CNT_W-1:0]                           num_vectors,
    output logic                                       busy,
    output logic                                       done,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [DATA_WIDTH*KERNEL_SIZE-1:0]          in_data,
    output logic                                       pe_en,
    output logic [DATA_WIDTH*KERNEL_SIZE-1:0]          pe_dataIn,
    output logic [WEIGHT_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] pe_weightsIn,
    output logic                                       out_valid,
    output logic [CNT_W-1:0]                           out_index
);

    localparam int               NUM_W   = KERNEL_SIZE * KERNEL_SIZE;
    localparam logic [IDX_W:0]   NUM_W_C = NUM_W[IDX_W:0];
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                            state_r;
    state_t                            state_next_s;
    logic [CNT_W-1:0]                  count_r;
    logic [CNT_W-1:0]                  issued_r;
    logic [CNT_W-1:0]                  retired_r;
    logic [PIPE_LATENCY-1:0]           valid_sr_r;
    logic [PIPE_LATENCY:0]             valid_chain_s;
    logic [WEIGHT_WIDTH*NUM_W-1:0]     weights_r;
    logic [DATA_WIDTH*KERNEL_SIZE-1:0] pe_data_r;
    logic                              pe_en_r;
    logic                              busy_r;
    logic                              done_r;
    logic                              done_next_s;
    logic                              job_start_s;
    logic                              fire_s;
    logic                              last_fire_s;
    logic                              last_out_s;
    logic                              in_ready_s;
    logic                              cfg_ok_s;

    // In RUN the issue count never reaches the latched count, since the last
    // handshake moves the FSM to DRAIN; the compare keeps in_ready self-limiting.
    assign in_ready_s  = (state_r == ST_RUN) && (issued_r < count_r);
    assign fire_s      = in_valid && in_ready_s && !abort;
    assign last_fire_s = fire_s && (issued_r == (count_r - CNT_ONE));
    assign last_out_s  = valid_sr_r[PIPE_LATENCY-1] && (retired_r == (count_r - CNT_ONE));
    assign cfg_ok_s    = cfg_wr && (state_r == ST_IDLE) && ({1'b0, cfg_addr} < NUM_W_C);

    // Bit 0 of the chain is the current pe_en; the register keeps the next PIPE_LATENCY stages.
    assign valid_chain_s = {valid_sr_r, pe_en_r};

    assign busy         = busy_r;
    assign done         = done_r;
    assign in_ready     = in_ready_s;
    assign pe_en        = pe_en_r;
    assign pe_dataIn    = pe_data_r;
    assign pe_weightsIn = weights_r;
    assign out_valid    = valid_sr_r[PIPE_LATENCY-1];
    assign out_index    = retired_r;

    // Next-state and job-control decode; abort overrides everything else.
    always_comb begin
        state_next_s = state_r;
        done_next_s  = 1'b0;
        job_start_s  = 1'b0;
        if (abort) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (num_vectors != '0) begin
                            state_next_s = ST_RUN;
                            job_start_s  = 1'b1;
                        end else begin
                            done_next_s = 1'b1;
                        end
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (last_fire_s) begin
                        state_next_s = ST_DRAIN;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (last_out_s) begin
                        state_next_s = ST_IDLE;
                        done_next_s  = 1'b1;
                    end else begin
                        state_next_s = ST_DRAIN;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register with registered busy/done status.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
            done_r  <= done_next_s;
        end
    end

    // Job length latch plus issue/retire counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_r   <= '0;
            issued_r  <= '0;
            retired_r <= '0;
        end else if (abort) begin
            count_r   <= '0;
            issued_r  <= '0;
            retired_r <= '0;
        end else if (job_start_s) begin
            count_r   <= num_vectors;
            issued_r  <= '0;
            retired_r <= '0;
        end else begin
            if (fire_s) begin
                issued_r <= issued_r + CNT_ONE;
            end
            if (valid_sr_r[PIPE_LATENCY-1]) begin
                retired_r <= retired_r + CNT_ONE;
            end
        end
    end

    // Array drive: pe_en pulses per accepted vector, data holds through bubbles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pe_en_r   <= 1'b0;
            pe_data_r <= '0;
        end else begin
            pe_en_r <= fire_s;
            if (fire_s) begin
                pe_data_r <= in_data;
            end
        end
    end

    // Result-valid shift register tracking pe_en through the array latency.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_sr_r <= '0;
        end else if (abort) begin
            valid_sr_r <= '0;
        end else begin
            valid_sr_r <= valid_chain_s[PIPE_LATENCY-1:0];
        end
    end

    // Weight bank: written only while idle, out-of-range addresses dropped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            weights_r <= '0;
        end else begin
            for (int i = 0; i < NUM_W; i++) begin
                if (cfg_ok_s && (cfg_addr == IDX_W'(i))) begin
                    weights_r[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] <= cfg_data;
                end
            end
        end
    end

endmodule

// File: doc/pe_array_scheduler.md
# pe_array_scheduler

Job-level controller for the `pe_wrapper` convolution array. It holds the K×K weight bank loaded over a config port and accepts input pixel vectors from an upstream valid/ready stream. For each job of `num_vectors` vectors it drives the array's enable and data, and it tags each result with a valid strobe and index after the fixed array latency. It sits between the line-buffer/DMA front end and the PE array, and signals job completion to the top-level sequencer.

## Interface
- `KERNEL_SIZE`, 3, kernel dimension K.
- `DATA_WIDTH`, 8, pixel width.
- `WEIGHT_WIDTH`, 8, weight width.
- `PIPE_LATENCY`, 4, cycles from `pe_en` high to the array's row sums being valid; must be ≥1.
- `CNT_W`, 16, width of job/vector counters.
- `IDX_W`, 4, weight address width; must satisfy 2^IDX_W ≥ K*K.
- `clk`  in  1  clock, all logic on rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `cfg_wr`  in  1  weight write strobe.
- `cfg_addr`  in  IDX_W  weight index (r*K + c).
- `cfg_data`  in  WEIGHT_WIDTH  weight value.
- `start`  in  1  job start pulse.
- `abort`  in  1  cancel current job.
- `num_vectors`  in  CNT_W  vectors in the job, sampled on accepted `start`.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle job-complete pulse.
- `in_valid`  in  1  upstream vector valid.
- `in_ready`  out  1  scheduler accepts vector.
- `in_data`  in  DATA_WIDTH*K  input pixel vector.
- `pe_en`  out  1  array enable.
- `pe_dataIn`  out  DATA_WIDTH*K  array input vector.
- `pe_weightsIn`  out  WEIGHT_WIDTH*K*K  weight bank, index i at bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH].
- `out_valid`  out  1  array output corresponds to an issued vector.
- `out_index`  out  CNT_W  0-based index of the vector whose result is valid.

## Operation
- Reset state:
  - State IDLE.
  - Outputs `busy`, `done`, `in_ready`, `pe_en`, `out_valid` are 0.
  - Outputs `pe_dataIn`, `pe_weightsIn`, `out_index` are 0.
  - Latency shift register and counters cleared.
- Weight bank: `cfg_wr` in IDLE writes `cfg_data` to entry `cfg_addr` on the next edge.
  - Writes outside IDLE are ignored.
  - Writes with `cfg_addr` ≥ K*K are ignored.
  - Bank is retained across jobs and abort; cleared only by reset.
- FSM states IDLE, RUN, DRAIN:
  - IDLE→RUN: `start`=1, `abort`=0, `num_vectors`≠0. Latch `num_vectors`; clear `issued` and `retired` counters.
  - IDLE, `start` with `num_vectors`=0: stay IDLE, pulse `done` next cycle.
  - RUN→DRAIN: on the handshake of vector `num_vectors`-1.
  - DRAIN→IDLE: on the cycle `out_valid`=1 with `out_index`=`num_vectors`-1. `done`=1 the following cycle.
  - Any state with `abort`=1 → IDLE next cycle.
    - On abort, `pe_en`, shift register and counters are cleared.
    - No `done` is produced.
    - Abort has priority over `start` in the same cycle.
- `start` while `busy`: ignored.
- `busy`=1 in RUN and DRAIN.
- `in_ready` is combinational: 1 iff state RUN and `issued` < latched count.
- Fire = `in_valid` & `in_ready`. On fire, the next edge registers:
  - `pe_en`=1;
  - `pe_dataIn`=`in_data`;
  - `issued`+=1.
- Without fire, next `pe_en`=0 and `pe_dataIn` holds its value (bubble).
- Valid tracking: PIPE_LATENCY-deep shift register fed by `pe_en`.
  - `out_valid` = last stage.
  - `out_index` = `retired` counter, incremented after each `out_valid`.
- Results stay ordered; bubbles never produce `out_valid`.
- Downstream has no backpressure; results must be consumed on `out_valid`.

## Timing
- Fire at edge t → `pe_en` high in cycle t+1 → `out_valid` high in cycle t+1+PIPE_LATENCY.
- Back-to-back fires give 1 vector/cycle throughput and contiguous `out_valid`.
- `done` rises 1 cycle after the last `out_valid`. `busy` falls on the same edge `done` rises.
- `start` → `in_ready` high in the next cycle (first RUN cycle).
- Asynchronous `rstn` deassertion mid-job: the job is lost. All outputs are at reset values immediately on assertion.

## Test plan
- Weight load: write weights 1..9 to addr 0..8 in IDLE. Write addr 12 with 0xFF. → `pe_weightsIn` = {9,…,1}, bytes 8..0; addr 12 has no effect. A write during RUN is ignored.
- Streaming job: `num_vectors`=5, `in_valid` held high. → 5 contiguous `in_ready` cycles; `pe_en` high 5 cycles. `out_valid` high cycles 6–10 after start with `out_index` 0–4. `done` in cycle 11; `busy` falls the same cycle.
- Bubbles: `num_vectors`=3, `in_valid` pattern 1,0,0,1,1. → `out_valid` pattern matches with gaps, `out_index` 0,1,2. `done` 1 cycle after index 2.
- Zero-length job: `start` with `num_vectors`=0. → `done` next cycle, `busy` stays 0, `pe_en` never asserted.
- Abort: `num_vectors`=8, assert `abort` after 3 fires. → next cycle IDLE: `busy`=0, `in_ready`=0, no further `out_valid`, no `done`. Weights unchanged. A new `start` runs a full job correctly.
- Reset mid-DRAIN: assert `rstn`=0. → all outputs 0 asynchronously; weights cleared to 0.
